adc_socket: RTL and testbench
=============================

// Module: adc_socket
// PURPOSE
//   APB slave that reads an external 12-bit SAR ADC: the input-side counterpart of the DAC output socket.
//   Sits on the SoC APB bus and issues conversion requests on software command or periodic timer.
//   Captures results, tracks valid/overrun/timeout status and raises an interrupt.
//   The ADC handshake is a held start level plus a single-cycle done pulse.
// PARAMETERS
//   ADC_W          12       result width; adc_data and DATA[ADC_W-1:0]
//   PERIOD_DEFAULT 16'd1000 reset value of PERIOD (cycles between continuous-mode starts)
//   TIMEOUT        16'd4095 max cycles in CONV waiting for adc_done before abort
// PORTS
//   sys_clk          in   1      system clock, all logic rising-edge
//   rst              in   1      synchronous reset, active-high
//   apb_adc_paddr    in   32     APB address; [7:2] decoded, others ignored
//   apb_adc_penable  in   1      APB enable
//   apb_adc_psel     in   1      APB select
//   apb_adc_pwrite   in   1      APB direction, 1 = write
//   apb_adc_pwdata   in   32     APB write data
//   adc_apb_prdata   out  32     APB read data
//   adc_start        out  1      conversion request to ADC, level
//   adc_done         in   1      1-cycle pulse from ADC; adc_data valid same cycle
//   adc_data         in   ADC_W  conversion result
//   adc_irq          out  1      interrupt, level
// BEHAVIOUR
//   Access: wr_acc = psel&pwrite&penable and rd_acc = psel&~pwrite&penable; no wait states (no pready).
//   Register map, by paddr[7:2]:
//     0 CTRL   RW  [0] CONT, [1] START (write-1 pulse, reads 0), [2] IRQ_EN
//     1 STATUS RW  [0] BUSY (RO), [1] VALID, [2] OVERRUN, [3] TOUT; [3:1] are write-1-to-clear
//     2 DATA   RO  [ADC_W-1:0] last result, upper bits 0; a read clears VALID
//     3 PERIOD RW  [15:0]
//     Other addresses read 0; writes to them are ignored.
//   prdata: combinational, register value when rd_acc, else 32'h0.
//   Reset: CTRL=0, STATUS=0, DATA=0, PERIOD=PERIOD_DEFAULT, period_cnt=0, tout_cnt=0.
//     Reset also forces state IDLE, adc_start=0, adc_irq=0.
//   Reset mid-conversion: adc_start deasserts at that edge; a done pulse arriving afterwards is ignored.
//   FSM states: IDLE, CONV.
//     IDLE -> CONV when trig. trig = (wr_acc to CTRL with pwdata[1]) | (CONT & period_cnt==0).
//       On entry: adc_start=1 from the next cycle, tout_cnt=0, period_cnt<=PERIOD.
//     CONV -> IDLE on adc_done: DATA<=adc_data and VALID<=1.
//       If VALID was already 1 and is not being cleared this cycle, OVERRUN<=1.
//     CONV -> IDLE when tout_cnt==TIMEOUT-1 without done: TOUT<=1, DATA unchanged.
//     adc_start deasserts on the edge that leaves CONV. BUSY = (state==CONV).
//   START write while in CONV is ignored (not queued).
//   Clearing CONT during CONV: the current conversion completes and no further auto-trigger occurs.
//   period_cnt: decrements by 1 per cycle in both states and saturates at 0.
//     PERIOD=0 gives back-to-back conversions, with one IDLE cycle between them.
//   Simultaneous events:
//     done with DATA read: VALID stays 1, DATA updated, OVERRUN not set.
//     done/timeout with STATUS W1C of the same bit: set wins.
//   adc_irq = IRQ_EN & (VALID|OVERRUN|TOUT), driven from registered flags; no combinational path from APB inputs.
//   The ADC is expected to hold adc_data stable only during the done cycle; no extra sampling latency is added.
// TESTING
//   1. One-shot: write CTRL=0x2; ADC done after 10 cycles with 0xABC.
//      -> adc_start high 10 cycles; STATUS=0x2; DATA reads 0x00000ABC; a second STATUS read gives 0x0.
//   2. Continuous: PERIOD=20, CTRL=0x1, ADC done after 5 cycles each time.
//      -> adc_start rising edges exactly 21 cycles apart; without DATA reads, OVERRUN set on 2nd done.
//   3. Timeout: START with adc_done tied 0.
//      -> adc_start held TIMEOUT cycles then drops; STATUS=0x8; DATA unchanged; W1C 0x8 clears it.
//   4. IRQ: CTRL=0x6, done with 0x123 -> adc_irq=1; read DATA -> adc_irq=0 next cycle.
//      Repeat with IRQ_EN=0 -> adc_irq stays 0.
//   5. Collisions: done in the same cycle as the DATA read -> VALID=1, OVERRUN=0.
//      done in the same cycle as STATUS W1C 0x2 -> VALID=1.
//      START during CONV -> no extra conversion.
//   6. Reset mid-CONV: assert rst with adc_start=1.
//      -> next edge adc_start=0, PERIOD=1000 (0x3E8), all status 0; a later done pulse has no effect.

Source files
------------

// File: rtl/adc_socket.sv
`default_nettype none
// ============================================================================
// Module  : adc_socket
// Brief   : APB slave driving a 12-bit SAR ADC (start level / done pulse),
//           with one-shot and periodic triggering, status flags and IRQ.
// Revision: 1.0 - initial release
// ============================================================================
module adc_socket #(
  parameter int unsigned ADC_W          = 12,
  parameter logic [15:0] PERIOD_DEFAULT = 16'd1000,
  parameter logic [15:0] TIMEOUT        = 16'd4095
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [31:0]      apb_adc_paddr,
  input  logic             apb_adc_penable,
  input  logic             apb_adc_psel,
  input  logic             apb_adc_pwrite,
  input  logic [31:0]      apb_adc_pwdata,
  output logic [31:0]      adc_apb_prdata,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_data,
  output logic             adc_irq
);

  localparam logic [5:0] ADDR_CTRL   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_DATA   = 6'd2;
  localparam logic [5:0] ADDR_PERIOD = 6'd3;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_CONV = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               cont_q, cont_d;
  logic               irq_en_q, irq_en_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               tout_q, tout_d;
  logic [ADC_W-1:0]   data_q, data_d;
  logic [15:0]        period_q, period_d;
  logic [15:0]        period_cnt_q, period_cnt_d;
  logic [15:0]        tout_cnt_q, tout_cnt_d;

  logic       wr_acc, rd_acc;
  logic [5:0] addr;
  logic       start_wr, valid_clr, trig;
  logic       unused_apb;

  assign wr_acc    = apb_adc_psel & apb_adc_pwrite & apb_adc_penable;
  assign rd_acc    = apb_adc_psel & ~apb_adc_pwrite & apb_adc_penable;
  assign addr      = apb_adc_paddr[7:2];
  assign start_wr  = wr_acc && (addr == ADDR_CTRL) && apb_adc_pwdata[1];
  assign valid_clr = (wr_acc && (addr == ADDR_STATUS) && apb_adc_pwdata[1]) ||
                     (rd_acc && (addr == ADDR_DATA));
  assign unused_apb = ^{apb_adc_paddr[31:8], apb_adc_paddr[1:0], apb_adc_pwdata[31:16]};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cont_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
      tout_q       <= 1'b0;
      data_q       <= '0;
      period_q     <= PERIOD_DEFAULT;
      period_cnt_q <= 16'd0;
      tout_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      cont_q       <= cont_d;
      irq_en_q     <= irq_en_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
      tout_q       <= tout_d;
      data_q       <= data_d;
      period_q     <= period_d;
      period_cnt_q <= period_cnt_d;
      tout_cnt_q   <= tout_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cont_d       = cont_q;
    irq_en_d     = irq_en_q;
    valid_d      = valid_q;
    ovr_d        = ovr_q;
    tout_d       = tout_q;
    data_d       = data_q;
    period_d     = period_q;
    tout_cnt_d   = tout_cnt_q;
    period_cnt_d = (period_cnt_q != 16'd0) ? period_cnt_q - 16'd1 : 16'd0;
    trig         = 1'b0;

    if (wr_acc && (addr == ADDR_CTRL)) begin
      cont_d   = apb_adc_pwdata[0];
      irq_en_d = apb_adc_pwdata[2];
    end
    if (wr_acc && (addr == ADDR_PERIOD)) begin
      period_d = apb_adc_pwdata[15:0];
    end
    if (wr_acc && (addr == ADDR_STATUS)) begin
      if (apb_adc_pwdata[2]) ovr_d  = 1'b0;
      if (apb_adc_pwdata[3]) tout_d = 1'b0;
    end
    if (valid_clr) valid_d = 1'b0;

    // Completion events come last so that a set beats a same-cycle clear.
    case (state_q)
      S_IDLE: begin
        trig = start_wr || (cont_q && (period_cnt_q == 16'd0));
        if (trig) begin
          state_d      = S_CONV;
          tout_cnt_d   = 16'd0;
          period_cnt_d = period_q;
        end
      end
      S_CONV: begin
        tout_cnt_d = tout_cnt_q + 16'd1;
        if (adc_done) begin
          state_d = S_IDLE;
          data_d  = adc_data;
          valid_d = 1'b1;
          if (valid_q && !valid_clr) ovr_d = 1'b1;
        end else if (tout_cnt_q == TIMEOUT - 16'd1) begin
          state_d = S_IDLE;
          tout_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    adc_apb_prdata = 32'h0;
    if (rd_acc) begin
      case (addr)
        ADDR_CTRL:   adc_apb_prdata = {29'h0, irq_en_q, 1'b0, cont_q};
        ADDR_STATUS: adc_apb_prdata = {28'h0, tout_q, ovr_q, valid_q, (state_q == S_CONV)};
        ADDR_DATA:   adc_apb_prdata = 32'(data_q);
        ADDR_PERIOD: adc_apb_prdata = {16'h0, period_q};
        default:     adc_apb_prdata = 32'h0;
      endcase
    end
  end

  assign adc_start = (state_q == S_CONV);
  assign adc_irq   = irq_en_q & (valid_q | ovr_q | tout_q);

endmodule
`default_nettype wire

// File: tb/tb_adc_socket.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_socket
// Brief   : Directed self-checking bench for adc_socket.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adc_socket;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = '0;
  logic        penable = 1'b0, psel = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        adc_start, adc_irq;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_socket dut (
    .sys_clk(clk), .rst(rst),
    .apb_adc_paddr(paddr), .apb_adc_penable(penable), .apb_adc_psel(psel),
    .apb_adc_pwrite(pwrite), .apb_adc_pwdata(pwdata), .adc_apb_prdata(prdata),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data), .adc_irq(adc_irq)
  );

  localparam logic [7:0] A_CTRL = 8'h00, A_STAT = 8'h04, A_DATA = 8'h08, A_PER = 8'h0C;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; paddr = {24'h0, a}; pwdata = d; penable = 1'b0;
    tick;
    penable = 1'b1;
    tick;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; paddr = {24'h0, a}; penable = 1'b0;
    tick;
    penable = 1'b1;
    #1 d = prdata;
    tick;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; adc_done = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  // done pulse lands in the n-th cycle counted from the current one
  task automatic adc_pulse_after(input int n, input logic [11:0] v);
    repeat (n - 1) tick;
    adc_done = 1'b1; adc_data = v;
    tick;
    adc_done = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int w);
    w = 0;
    while (adc_start !== 1'b1 && w < budget) begin
      tick;
      w++;
    end
    if (adc_start !== 1'b1) w = -1;
  endtask

  task automatic test_reset;
    logic [7:0]  addrs [5];
    logic [31:0] exps  [5];
    logic [31:0] d;
    addrs = '{A_CTRL, A_STAT, A_DATA, A_PER, 8'h10};
    exps  = '{32'h0, 32'h0, 32'h0, 32'h3E8, 32'h0};
    do_reset;
    checks++;
    if (adc_start !== 1'b0 || adc_irq !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got start=%b irq=%b want 0 0", adc_start, adc_irq);
    end
    checks++;
    if (prdata !== 32'h0) begin
      errors++; $display("FAIL idle_prdata got %h want 0", prdata);
    end
    apb_write(8'h10, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      apb_read(addrs[i], d);
      checks++;
      if (d !== exps[i]) begin
        errors++; $display("FAIL reset_reg[%h] got %h want %h", addrs[i], d, exps[i]);
      end
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] d;
    int hi;
    do_reset;
    apb_write(A_CTRL, 32'h2);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (adc_start === 1'b1) hi++;
      if (i == 9) begin adc_done = 1'b1; adc_data = 12'hABC; end
      tick;
    end
    adc_done = 1'b0;
    checks++;
    if (hi != 10 || adc_start !== 1'b0) begin
      errors++; $display("FAIL oneshot_start got high=%0d after=%b want 10 0", hi, adc_start);
    end
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL oneshot_status got %h want 2", d); end
    apb_read(A_DATA, d);
    checks++;
    if (d !== 32'h0000_0ABC) begin errors++; $display("FAIL oneshot_data got %h want abc", d); end
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL oneshot_status2 got %h want 0", d); end
  endtask

  task automatic test_continuous;
    logic [31:0] d;
    int w, t1, t2, t3;
    do_reset;
    apb_write(A_PER, 32'd20);
    apb_write(A_CTRL, 32'h1);
    wait_start(10, w); t1 = cyc;
    adc_pulse_after(5, 12'h101);
    wait_start(40, w); t2 = cyc;
    adc_pulse_after(5, 12'h202);
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h6) begin errors++; $display("FAIL cont_overrun got %h want 6", d); end
    wait_start(40, w); t3 = cyc;
    checks++;
    if (t2 - t1 != 21) begin errors++; $display("FAIL cont_gap1 got %0d want 21", t2 - t1); end
    checks++;
    if (t3 - t2 != 21 || w < 0) begin
      errors++; $display("FAIL cont_gap2 got %0d want 21", t3 - t2);
    end
    apb_write(A_CTRL, 32'h0);
    adc_pulse_after(3, 12'h303);
    wait_start(60, w);
    checks++;
    if (w != -1) begin errors++; $display("FAIL cont_stop got restart after %0d want none", w); end
  endtask

  task automatic test_back_to_back;
    int w, t1, t2;
    do_reset;
    apb_write(A_PER, 32'd0);
    apb_write(A_CTRL, 32'h1);
    wait_start(10, w); t1 = cyc;
    adc_pulse_after(3, 12'h011);
    wait_start(10, w); t2 = cyc;
    checks++;
    if (t2 - t1 != 4 || w < 0) begin
      errors++; $display("FAIL b2b_gap got %0d want 4", t2 - t1);
    end
    apb_write(A_CTRL, 32'h0);
    adc_pulse_after(1, 12'h022);
    wait_start(20, w);
    checks++;
    if (w != -1) begin errors++; $display("FAIL b2b_stop got restart after %0d want none", w); end
  endtask

  task automatic test_timeout;
    logic [31:0] d;
    int n;
    do_reset;
    apb_write(A_CTRL, 32'h2);
    adc_pulse_after(2, 12'h5A5);
    apb_read(A_DATA, d);
    apb_write(A_CTRL, 32'h2);
    n = 0;
    while (adc_start === 1'b1 && n < 5000) begin
      n++;
      tick;
    end
    checks++;
    if (n != 4095) begin errors++; $display("FAIL tout_len got %0d want 4095", n); end
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL tout_status got %h want 8", d); end
    apb_read(A_DATA, d);
    checks++;
    if (d !== 32'h5A5) begin errors++; $display("FAIL tout_data got %h want 5a5", d); end
    apb_write(A_STAT, 32'h8);
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL tout_w1c got %h want 0", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    do_reset;
    apb_write(A_CTRL, 32'h6);
    adc_pulse_after(3, 12'h123);
    checks++;
    if (adc_irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", adc_irq); end
    apb_read(A_DATA, d);
    checks++;
    if (d !== 32'h123) begin errors++; $display("FAIL irq_data got %h want 123", d); end
    checks++;
    if (adc_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", adc_irq); end
    apb_write(A_CTRL, 32'h2);
    adc_pulse_after(3, 12'h0AA);
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h2 || adc_irq !== 1'b0) begin
      errors++; $display("FAIL irq_disabled got status=%h irq=%b want 2 0", d, adc_irq);
    end
  endtask

  task automatic test_collisions;
    logic [31:0] d;
    int w;
    do_reset;
    apb_write(A_CTRL, 32'h2);
    adc_pulse_after(2, 12'h111);
    apb_write(A_CTRL, 32'h2);
    psel = 1'b1; pwrite = 1'b0; paddr = {24'h0, A_DATA}; penable = 1'b0;
    tick;
    penable = 1'b1; adc_done = 1'b1; adc_data = 12'h222;
    #1 d = prdata;
    tick;
    adc_done = 1'b0; psel = 1'b0; penable = 1'b0;
    checks++;
    if (d !== 32'h111) begin errors++; $display("FAIL col_rd_old got %h want 111", d); end
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL col_rd_status got %h want 2", d); end
    apb_read(A_DATA, d);
    checks++;
    if (d !== 32'h222) begin errors++; $display("FAIL col_rd_data got %h want 222", d); end

    apb_write(A_CTRL, 32'h2);
    adc_pulse_after(2, 12'h333);
    apb_write(A_CTRL, 32'h2);
    psel = 1'b1; pwrite = 1'b1; paddr = {24'h0, A_STAT}; pwdata = 32'h2; penable = 1'b0;
    tick;
    penable = 1'b1; adc_done = 1'b1; adc_data = 12'h444;
    tick;
    adc_done = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL col_w1c_status got %h want 2", d); end
    apb_read(A_DATA, d);
    checks++;
    if (d !== 32'h444) begin errors++; $display("FAIL col_w1c_data got %h want 444", d); end

    apb_write(A_CTRL, 32'h2);
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL col_busy got %h want 1", d); end
    apb_write(A_CTRL, 32'h2);
    adc_pulse_after(2, 12'h555);
    wait_start(20, w);
    checks++;
    if (w != -1) begin errors++; $display("FAIL col_start_conv got restart after %0d want none", w); end
    apb_read(A_DATA, d);
    checks++;
    if (d !== 32'h555) begin errors++; $display("FAIL col_start_data got %h want 555", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    do_reset;
    apb_write(A_PER, 32'h55);
    apb_write(A_CTRL, 32'h7);
    checks++;
    if (adc_start !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b want 1", adc_start); end
    rst = 1'b1;
    tick;
    checks++;
    if (adc_start !== 1'b0) begin errors++; $display("FAIL rmid_start got %b want 0", adc_start); end
    rst = 1'b0;
    adc_done = 1'b1; adc_data = 12'hFFF;
    tick;
    adc_done = 1'b0;
    tick;
    apb_read(A_PER, d);
    checks++;
    if (d !== 32'h3E8) begin errors++; $display("FAIL rmid_period got %h want 3e8", d); end
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rmid_status got %h want 0", d); end
    apb_read(A_DATA, d);
    checks++;
    if (d !== 32'h0 || adc_irq !== 1'b0) begin
      errors++; $display("FAIL rmid_data got data=%h irq=%b want 0 0", d, adc_irq);
    end
    apb_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rmid_ctrl got %h want 0", d); end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_continuous;
    test_back_to_back;
    test_timeout;
    test_irq;
    test_collisions;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
